// File: rtl/riscv_types_pkg.sv
// ----------------------------------------------------------------------------
// riscv_types
//   Types and constants shared by the RV32 pipeline stages.
//   memory_info    : EX/MEM control consumed by the memory stage.
//   writeback_info : control handed to the writeback stage.
//   MEM_SZ_*       : unshifted byte-enable patterns used as mem_size.
//   mem_state_e    : memory-stage access state.
// ----------------------------------------------------------------------------
package riscv_types;

   localparam logic [3:0] MEM_SZ_B = 4'b0001;
   localparam logic [3:0] MEM_SZ_H = 4'b0011;
   localparam logic [3:0] MEM_SZ_W = 4'b1111;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_e;

   typedef struct packed {
      logic       rd_wren;
      logic [4:0] rd_addr;
   } writeback_info;

   typedef struct packed {
      logic          mem_load;
      logic          mem_wren;
      logic [3:0]    mem_size;
      logic          mem_unsign;
      writeback_info wb;
   } memory_info;

endpackage

// File: rtl/mem_stage_load_align.sv
// ----------------------------------------------------------------------------
// load_align
//   Combinational load alignment: shifts the addressed byte lane down to bit 0
//   and sign- or zero-extends according to the access size.
// Ports
//   rdata_i  in  32  raw word returned by data memory
//   off_i    in  2   byte offset (address bits [1:0])
//   size_i   in  4   unshifted byte-enable pattern (B/H/W)
//   unsign_i in  1   1 = zero-extend, 0 = sign-extend
//   result_o out 32  aligned, extended load value
// ----------------------------------------------------------------------------
module load_align
   import riscv_types::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [3:0]  size_i,
   input  logic        unsign_i,
   output logic [31:0] result_o
);

   logic [31:0] shifted;

   assign shifted = rdata_i >> {off_i, 3'b000};

   always_comb begin
      result_o = shifted;
      case (size_i)
         MEM_SZ_B: result_o = {{24{~unsign_i & shifted[7]}},  shifted[7:0]};
         MEM_SZ_H: result_o = {{16{~unsign_i & shifted[15]}}, shifted[15:0]};
         default:  result_o = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//   Memory stage of the 5-stage RV32 pipeline (between EX/MEM and MEM/WB).
//   Issues data-memory requests with a req/ack handshake, lane-aligns store
//   data and byte enables, aligns/extends load data, and registers the result
//   for writeback. Upstream is stalled while an access waits for its ack.
//
// Parameters
//   XLEN          datapath/address width (32 only)
//   DMEM_TIMEOUT  max cycles waiting for ack; 0 = wait forever
//
// Ports
//   i_clk, i_rst_n             clock / asynchronous active-low reset
//   i_valid, i_info            instruction valid + control from EX/MEM
//   i_alu_result, i_store_data effective address / ALU result, store data
//   o_stall                    hold EX/MEM and everything upstream
//   o_dmem_req/we/addr/wdata/bmask, i_dmem_ack, i_dmem_rdata : data memory
//   o_wb_valid, o_wb_info, o_wb_data                          : MEM/WB
//   o_bus_err                  one-cycle pulse on timeout abort
//   o_misalign                 (MEM_MISALIGN_TRAP_EN only) misaligned-access
//                              pulse alongside o_wb_valid
//
// Build option
//   MEM_MISALIGN_TRAP_EN : misaligned H/W accesses issue no request and are
//                          reported on o_misalign instead. Without it they
//                          proceed and lanes shifted past byte 3 are dropped.
// ----------------------------------------------------------------------------
module mem_stage
   import riscv_types::*;
#(
   parameter int XLEN         = 32,
   parameter int DMEM_TIMEOUT = 0
)(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   input  memory_info      i_info,
   input  logic [XLEN-1:0] i_alu_result,
   input  logic [XLEN-1:0] i_store_data,
   output logic            o_stall,
   output logic            o_dmem_req,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic [XLEN-1:0] o_dmem_wdata,
   output logic [3:0]      o_dmem_bmask,
   input  logic            i_dmem_ack,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_wb_valid,
   output writeback_info   o_wb_info,
   output logic [XLEN-1:0] o_wb_data,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic            o_misalign,
`endif
   output logic            o_bus_err
);

   mem_state_e      state_q, state_d;
   logic [XLEN-1:0] alu_q, alu_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [3:0]      bmask_q, bmask_d;
   logic [3:0]      size_q, size_d;
   logic            we_q, we_d;
   logic            unsign_q, unsign_d;
   writeback_info   pend_info_q, pend_info_d;

   // One-entry holding slot for a non-request instruction accepted in the
   // same cycle an access completes: both want MEM/WB on the same edge, so
   // the later one is emitted one cycle after, keeping program order.
   logic            skid_vld_q, skid_vld_d;
   writeback_info   skid_info_q, skid_info_d;
   logic [XLEN-1:0] skid_data_q, skid_data_d;

   logic            wb_valid_q, wb_valid_d;
   writeback_info   wb_info_q, wb_info_d;
   logic [XLEN-1:0] wb_data_q, wb_data_d;
   logic            bus_err_q, bus_err_d;

   logic            busy, accept, is_mem, misal, issue, direct;
   logic            timeout_hit, complete;
   writeback_info   direct_info;
   logic [XLEN-1:0] load_result;

   assign busy     = (state_q == BUSY);
   assign o_stall  = busy & ~i_dmem_ack;
   assign accept   = i_valid & ~o_stall;
   assign is_mem   = i_info.mem_load | i_info.mem_wren;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misal = ((i_info.mem_size == MEM_SZ_H) && i_alu_result[0]) ||
                  ((i_info.mem_size == MEM_SZ_W) && (i_alu_result[1:0] != 2'b00));
`else
   assign misal = 1'b0;
`endif

   // issue  : accepted op that starts a memory access
   // direct : accepted op that completes without memory (ALU op or trap)
   assign issue    = accept & is_mem & ~misal;
   assign direct   = accept & ~issue;
   assign complete = busy & (i_dmem_ack | timeout_hit);

   generate
      if (DMEM_TIMEOUT > 0) begin : g_timeout
         localparam int CNT_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT + 1) : 1;
         logic [CNT_W-1:0] cnt_q;

         // Counts BUSY cycles; cleared whenever a new access is issued.
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               cnt_q <= '0;
            end else if (issue) begin
               cnt_q <= '0;
            end else if (busy) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end

         assign timeout_hit = busy & ~i_dmem_ack &
                              (cnt_q == CNT_W'(DMEM_TIMEOUT - 1));
      end else begin : g_no_timeout
         assign timeout_hit = 1'b0;
      end
   endgenerate

   load_align u_load_align (
      .rdata_i  (i_dmem_rdata),
      .off_i    (alu_q[1:0]),
      .size_i   (size_q),
      .unsign_i (unsign_q),
      .result_o (load_result)
   );

   always_comb begin
      direct_info         = i_info.wb;
      // Only a trapped memory op reaches here as a memory op; it never writes rd.
      direct_info.rd_wren = i_info.wb.rd_wren & ~is_mem;
   end

   always_comb begin
      state_d     = state_q;
      alu_d       = alu_q;
      wdata_d     = wdata_q;
      bmask_d     = bmask_q;
      size_d      = size_q;
      we_d        = we_q;
      unsign_d    = unsign_q;
      pend_info_d = pend_info_q;
      skid_vld_d  = 1'b0;
      skid_info_d = skid_info_q;
      skid_data_d = skid_data_q;
      wb_valid_d  = 1'b0;
      wb_info_d   = wb_info_q;
      wb_data_d   = wb_data_q;
      bus_err_d   = 1'b0;

      if (issue) begin
         state_d     = BUSY;
         alu_d       = i_alu_result;
         wdata_d     = i_store_data << {i_alu_result[1:0], 3'b000};
         bmask_d     = i_info.mem_size << i_alu_result[1:0];
         size_d      = i_info.mem_size;
         we_d        = i_info.mem_wren;   // load+store together acts as store
         unsign_d    = i_info.mem_unsign;
         pend_info_d = i_info.wb;
         pend_info_d.rd_wren = i_info.wb.rd_wren & ~i_info.mem_wren;
      end else if (complete) begin
         state_d = IDLE;
      end

      if (complete) begin
         wb_valid_d = 1'b1;
         wb_info_d  = pend_info_q;
         wb_data_d  = alu_q;
         if (timeout_hit) begin
            wb_info_d.rd_wren = 1'b0;
            bus_err_d         = 1'b1;
         end else if (!we_q) begin
            wb_data_d = load_result;
         end
      end else if (skid_vld_q) begin
         wb_valid_d = 1'b1;
         wb_info_d  = skid_info_q;
         wb_data_d  = skid_data_q;
      end else if (direct) begin
         wb_valid_d = 1'b1;
         wb_info_d  = direct_info;
         wb_data_d  = i_alu_result;
      end

      if (direct && (complete || skid_vld_q)) begin
         skid_vld_d  = 1'b1;
         skid_info_d = direct_info;
         skid_data_d = i_alu_result;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         alu_q       <= '0;
         wdata_q     <= '0;
         bmask_q     <= '0;
         size_q      <= '0;
         we_q        <= 1'b0;
         unsign_q    <= 1'b0;
         pend_info_q <= '0;
         skid_vld_q  <= 1'b0;
         skid_info_q <= '0;
         skid_data_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_info_q   <= '0;
         wb_data_q   <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_q       <= alu_d;
         wdata_q     <= wdata_d;
         bmask_q     <= bmask_d;
         size_q      <= size_d;
         we_q        <= we_d;
         unsign_q    <= unsign_d;
         pend_info_q <= pend_info_d;
         skid_vld_q  <= skid_vld_d;
         skid_info_q <= skid_info_d;
         skid_data_q <= skid_data_d;
         wb_valid_q  <= wb_valid_d;
         wb_info_q   <= wb_info_d;
         wb_data_q   <= wb_data_d;
         bus_err_q   <= bus_err_d;
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   logic skid_mis_q, mis_q;

   // Tracks whether the op leaving through MEM/WB was a trapped access.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         skid_mis_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         mis_q <= complete   ? 1'b0 :
                  skid_vld_q ? skid_mis_q : (direct & is_mem);
         if (direct) begin
            skid_mis_q <= is_mem;
         end
      end
   end

   assign o_misalign = mis_q;
`endif

   // Request is tied to BUSY so an asynchronous reset drops it at once.
   assign o_dmem_req   = busy;
   assign o_dmem_we    = we_q;
   assign o_dmem_addr  = {alu_q[XLEN-1:2], 2'b00};
   assign o_dmem_wdata = wdata_q;
   assign o_dmem_bmask = bmask_q;
   assign o_wb_valid   = wb_valid_q;
   assign o_wb_info    = wb_info_q;
   assign o_wb_data    = wb_data_q;
   assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage (DMEM_TIMEOUT = 4, default build).
//   The bench acts as both EX/MEM producer and data memory. A reference model
//   tracks the outstanding access, expected request fields, and an in-order
//   queue of expected writeback results derived from the access rules.
// ----------------------------------------------------------------------------
module tb_mem_stage;
   import riscv_types::*;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_valid;
   memory_info    i_info;
   logic [31:0]   i_alu_result;
   logic [31:0]   i_store_data;
   logic          o_stall;
   logic          o_dmem_req;
   logic          o_dmem_we;
   logic [31:0]   o_dmem_addr;
   logic [31:0]   o_dmem_wdata;
   logic [3:0]    o_dmem_bmask;
   logic          i_dmem_ack;
   logic [31:0]   i_dmem_rdata;
   logic          o_wb_valid;
   writeback_info o_wb_info;
   logic [31:0]   o_wb_data;
   logic          o_bus_err;

   always #5 i_clk = ~i_clk;

   mem_stage #(.XLEN(32), .DMEM_TIMEOUT(4)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .i_info       (i_info),
      .i_alu_result (i_alu_result),
      .i_store_data (i_store_data),
      .o_stall      (o_stall),
      .o_dmem_req   (o_dmem_req),
      .o_dmem_we    (o_dmem_we),
      .o_dmem_addr  (o_dmem_addr),
      .o_dmem_wdata (o_dmem_wdata),
      .o_dmem_bmask (o_dmem_bmask),
      .i_dmem_ack   (i_dmem_ack),
      .i_dmem_rdata (i_dmem_rdata),
      .o_wb_valid   (o_wb_valid),
      .o_wb_info    (o_wb_info),
      .o_wb_data    (o_wb_data),
      .o_bus_err    (o_bus_err)
   );

   typedef struct {
      writeback_info info;
      logic [31:0]   data;
   } wb_exp_t;

   int n_vec = 0;
   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   wb_exp_t       exp_q[$];
   bit            outstanding = 0;
   int            wait_cnt    = 0;
   int            delay       = 0;
   bit            berr_next   = 0;
   bit            wb_seen     = 0;
   logic [31:0]   r_alu, r_addr, r_wdata;
   logic [3:0]    r_bmask, r_size;
   logic          r_we, r_uns;
   writeback_info r_info;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic memory_info mk(input logic ld, input logic st, input logic [3:0] sz,
                                     input logic uns, input logic wr, input logic [4:0] rd);
      memory_info m;
      m.mem_load   = ld;
      m.mem_wren   = st;
      m.mem_size   = sz;
      m.mem_unsign = uns;
      m.wb.rd_wren = wr;
      m.wb.rd_addr = rd;
      return m;
   endfunction

   function automatic logic [3:0] ref_bmask(input logic [3:0] sz, input logic [1:0] off);
      int m;
      m = int'(sz) * (1 << off);
      return 4'(m % 16);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [1:0] off);
      logic [63:0] p;
      p = {32'b0, sd} * (64'd1 << (8 * off));
      return p[31:0];
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                            input logic [3:0] sz, input logic uns);
      logic [31:0] w;
      int v;
      w = rd / (32'd1 << (8 * off));
      if (sz == MEM_SZ_B) begin
         v = int'(w % 256);
         if (!uns && v >= 128) v = v - 256;
         return v;
      end else if (sz == MEM_SZ_H) begin
         v = int'(w % 65536);
         if (!uns && v >= 32768) v = v - 65536;
         return v;
      end
      return w;
   endfunction

   // One clock cycle: drive inputs (called at posedge+1), check at negedge,
   // advance the model, return at the next posedge+1.
   task automatic cycle(input logic v, input memory_info inf, input logic [31:0] alu,
                        input logic [31:0] sd, input logic ack, input logic [31:0] rdata);
      bit      exp_stall, tmo;
      wb_exp_t e;
      i_valid      = v;
      i_info       = inf;
      i_alu_result = alu;
      i_store_data = sd;
      i_dmem_ack   = ack;
      i_dmem_rdata = rdata;
      @(negedge i_clk);
      exp_stall = outstanding && !ack;
      tmo       = outstanding && !ack && (wait_cnt == 3);
      check("stall", o_stall, exp_stall);
      check("dmem_req", o_dmem_req, outstanding);
      check("bus_err", o_bus_err, berr_next);
      if (outstanding) begin
         check("dmem_addr", o_dmem_addr, r_addr);
         check("dmem_we", o_dmem_we, r_we);
         check("dmem_wdata", o_dmem_wdata, r_wdata);
         check("dmem_bmask", o_dmem_bmask, r_bmask);
      end
      wb_seen = (o_wb_valid === 1'b1);
      if (wb_seen) begin
         if (exp_q.size() == 0) begin
            check("wb_spurious_valid", o_wb_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("wb_info", {26'b0, o_wb_info}, {26'b0, e.info});
            check("wb_data", o_wb_data, e.data);
         end
      end
      // model update
      berr_next = 0;
      if (outstanding) begin
         if (ack) begin
            e.info = r_info;
            e.data = r_we ? r_alu : ref_load(rdata, r_alu[1:0], r_size, r_uns);
            exp_q.push_back(e);
            outstanding = 0;
         end else if (tmo) begin
            e.info = r_info;
            e.info.rd_wren = 1'b0;
            e.data = r_alu;
            exp_q.push_back(e);
            outstanding = 0;
            berr_next = 1;
         end else begin
            wait_cnt++;
         end
      end
      if (v && !exp_stall) begin
         if (inf.mem_load || inf.mem_wren) begin
            outstanding = 1;
            wait_cnt = 0;
            delay    = $urandom_range(0, 3);
            r_alu    = alu;
            r_addr   = (alu / 4) * 4;
            r_we     = inf.mem_wren;
            r_wdata  = ref_wdata(sd, alu[1:0]);
            r_bmask  = ref_bmask(inf.mem_size, alu[1:0]);
            r_size   = inf.mem_size;
            r_uns    = inf.mem_unsign;
            r_info   = inf.wb;
            if (inf.mem_wren) r_info.rd_wren = 1'b0;
         end else begin
            e.info = inf.wb;
            e.data = alu;
            exp_q.push_back(e);
         end
      end
      n_vec++;
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_req"},      o_dmem_req,   1'b0);
      check({tag, "_we"},       o_dmem_we,    1'b0);
      check({tag, "_addr"},     o_dmem_addr,  32'h0);
      check({tag, "_wdata"},    o_dmem_wdata, 32'h0);
      check({tag, "_bmask"},    o_dmem_bmask, 4'h0);
      check({tag, "_wb_valid"}, o_wb_valid,   1'b0);
      check({tag, "_wb_info"},  {26'b0, o_wb_info}, 32'h0);
      check({tag, "_wb_data"},  o_wb_data,    32'h0);
      check({tag, "_bus_err"},  o_bus_err,    1'b0);
      check({tag, "_stall"},    o_stall,      1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && (outstanding || exp_q.size() > 0); k++) begin
         cycle(1'b0, '0, 32'h0, 32'h0, outstanding, $urandom());
      end
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   memory_info nop, alu_op, lb, lbu, sh, lw;

   initial begin
      nop    = mk(0, 0, MEM_SZ_W, 0, 0, 5'd0);
      alu_op = mk(0, 0, MEM_SZ_W, 0, 1, 5'd5);
      lb     = mk(1, 0, MEM_SZ_B, 0, 1, 5'd7);
      lbu    = mk(1, 0, MEM_SZ_B, 1, 1, 5'd8);
      sh     = mk(0, 1, MEM_SZ_H, 0, 0, 5'd0);
      lw     = mk(1, 0, MEM_SZ_W, 0, 1, 5'd9);
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_info = nop;
      i_alu_result = '0;
      i_store_data = '0;
      i_dmem_ack = 1'b0;
      i_dmem_rdata = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check_idle("reset");
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;

      // ALU op: one-cycle latency, no request
      cycle(1, alu_op, 32'h1234, 32'h0, 0, 32'h0);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("alu_wb_latency", wb_seen, 1'b1);

      // LB 0x103, ack on the 4th BUSY cycle
      cycle(1, lb, 32'h103, 32'h0, 0, 32'h0);
      repeat (3) cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      cycle(0, nop, 32'h0, 32'h0, 1, 32'h80FF_0000);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("lb_wb_seen", wb_seen, 1'b1);
      check("lb_sext", o_wb_data, 32'hFFFF_FF80);

      // LBU same address
      cycle(1, lbu, 32'h103, 32'h0, 0, 32'h0);
      cycle(0, nop, 32'h0, 32'h0, 1, 32'h80FF_0000);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("lbu_zext", o_wb_data, 32'h0000_0080);

      // SH 0x202
      cycle(1, sh, 32'h202, 32'hABCD, 0, 32'h0);
      check("sh_addr", o_dmem_addr, 32'h200);
      check("sh_bmask", o_dmem_bmask, 4'b1100);
      check("sh_wdata", o_dmem_wdata, 32'hABCD_0000);
      check("sh_we", o_dmem_we, 1'b1);
      cycle(0, nop, 32'h0, 32'h0, 1, 32'h0);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("sh_rd_wren", o_wb_info.rd_wren, 1'b0);

      // back-to-back loads, no IDLE gap
      cycle(1, lw, 32'h400, 32'h0, 0, 32'h0);
      cycle(1, lw, 32'h404, 32'h0, 1, 32'h1111_2222);
      check("b2b_req_no_gap", o_dmem_req, 1'b1);
      cycle(0, nop, 32'h0, 32'h0, 1, 32'h3333_4444);
      check("b2b_first_wb", wb_seen, 1'b1);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("b2b_second_wb", wb_seen, 1'b1);

      // timeout: ack never arrives
      cycle(1, lw, 32'h500, 32'h0, 0, 32'h0);
      repeat (4) cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("tmo_bus_err", o_bus_err, 1'b1);
      check("tmo_req_dropped", o_dmem_req, 1'b0);
      check("tmo_stall_released", o_stall, 1'b0);
      check("tmo_wb_valid", o_wb_valid, 1'b1);
      check("tmo_rd_wren", o_wb_info.rd_wren, 1'b0);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         memory_info inf;
         logic       ack;
         int         kind;
         logic [3:0] sz;
         kind = $urandom_range(0, 9);
         case ($urandom_range(0, 2))
            0:       sz = MEM_SZ_B;
            1:       sz = MEM_SZ_H;
            default: sz = MEM_SZ_W;
         endcase
         inf = mk(kind inside {[4:6], 9}, kind inside {[7:9]}, sz, 1'($urandom()),
                  1'($urandom()), 5'($urandom()));
         ack = outstanding ? (wait_cnt == delay) : ($urandom_range(0, 3) == 0);
         cycle(1'($urandom_range(0, 9) < 7), inf, $urandom(), $urandom(), ack, $urandom());
      end
      drain();

      // asynchronous reset in the middle of an access
      cycle(1, lw, 32'h600, 32'h0, 0, 32'h0);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      i_rst_n = 1'b0;
      #1;
      check("arst_req_drop", o_dmem_req, 1'b0);
      outstanding = 0;
      berr_next   = 0;
      exp_q.delete();
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check_idle("post_arst");
      cycle(1, alu_op, 32'h5A5A, 32'h0, 0, 32'h0);
      cycle(0, nop, 32'h0, 32'h0, 0, 32'h0);
      check("post_arst_alu_wb", wb_seen, 1'b1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
